// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule sequencer and its round-key buffer.
package aes_pkg;

    // Round count and derived buffer depth; only AES-128 is supported.
    localparam int unsigned AES_NR     = 10;
    localparam int unsigned RK_ENTRIES = AES_NR + 1;
    localparam int unsigned KEY_BITS   = 128;

    // First and last round constants of the AES-128 schedule.
    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_FINAL = 8'h36;

    typedef logic [KEY_BITS-1:0] round_key_t;
    typedef logic [3:0]          rk_idx_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLookup,
        StUpdate,
        StFinal,
        StDone
    } aes_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rk_buffer.sv
// Round-key register file: one synchronous write port fed by the sequencer and one
// registered read port for the cipher core, with an index range check.
module aes_rk_buffer
    import aes_pkg::*;
#(
    parameter int unsigned Entries = RK_ENTRIES,
    parameter int unsigned Width   = KEY_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  rk_idx_t          wr_idx,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    input  rk_idx_t          rd_idx,
    output logic [Width-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_err
);

    localparam rk_idx_t LastIdx = rk_idx_t'(Entries - 1);

    logic [Width-1:0] mem_q [Entries];
    logic [Width-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             rd_err_q;
    logic             wr_in_range;
    logic             rd_in_range;

    assign wr_in_range = (wr_idx <= LastIdx);
    assign rd_in_range = (rd_idx <= LastIdx);

    // Storage array; cleared on reset so stale keys never survive an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Entries; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Registered read: out-of-range indices return zero with an error pulse.
    // Without a read the data register holds its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_err_q   <= rd_en && !rd_in_range;
            if (rd_en) begin
                rd_data_q <= rd_in_range ? mem_q[rd_idx] : '0;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: accepts a cipher key, steps the external expansion
// datapath through load and ten rounds while generating round constants, and collects
// every round key into a buffer the cipher core reads by index.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR    = AES_NR,
    parameter int unsigned KEY_W = KEY_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             kx_load,
    output logic             kx_advance,
    output logic [31:0]      kx_rcon,
    input  logic [KEY_W-1:0] kx_key,
    output logic [KEY_W-1:0] kx_key_in,
    output logic             keys_ready,
    output logic             busy,
    input  logic             rk_rd_en,
    input  logic [3:0]       rk_rd_idx,
    output logic [KEY_W-1:0] rk_rd_data,
    output logic             rk_rd_valid,
    output logic             rk_rd_err
);

    localparam rk_idx_t LastRound = rk_idx_t'(NR);

    aes_state_e       state_q;
    rk_idx_t          r_q;
    logic [7:0]       rc_q;
    logic [KEY_W-1:0] kx_key_in_q;
    logic             key_ready_q;
    logic             busy_q;
    logic             keys_ready_q;
    logic             kx_load_q;
    logic             kx_advance_q;
    logic [31:0]      kx_rcon_q;

    logic             buf_wr_en;
    rk_idx_t          buf_wr_idx;
    logic             buf_rd_en;

    // Sequencer: state, round counter, round constant and all registered datapath controls.
    // Control outputs are loaded on entry to the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            r_q          <= '0;
            rc_q         <= '0;
            kx_key_in_q  <= '0;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_ready_q <= 1'b0;
            kx_load_q    <= 1'b0;
            kx_advance_q <= 1'b0;
            kx_rcon_q    <= '0;
        end else begin
            kx_load_q    <= 1'b0;
            kx_advance_q <= 1'b0;
            kx_rcon_q    <= '0;
            case (state_q)
                StIdle, StDone: begin
                    if (key_valid) begin
                        kx_key_in_q  <= key_in;
                        keys_ready_q <= 1'b0;
                        key_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        kx_load_q    <= 1'b1;
                        kx_advance_q <= 1'b1;
                        state_q      <= StLoad;
                    end
                end
                StLoad: begin
                    r_q     <= rk_idx_t'(1);
                    rc_q    <= RCON_FIRST;
                    state_q <= StLookup;
                end
                StLookup: begin
                    // Sbox settle cycle; the next cycle advances the datapath.
                    kx_advance_q <= 1'b1;
                    kx_rcon_q    <= {rc_q, 24'h0};
                    state_q      <= StUpdate;
                end
                StUpdate: begin
                    rc_q <= xtime(rc_q);
                    if (r_q == LastRound) begin
                        state_q <= StFinal;
                    end else begin
                        r_q     <= r_q + rk_idx_t'(1);
                        state_q <= StLookup;
                    end
                end
                StFinal: begin
                    keys_ready_q <= 1'b1;
                    key_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= StDone;
                end
                default: begin
                    state_q     <= StIdle;
                    key_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Buffer write strobe: round r-1 is captured in LOOKUP, the last round key in FINAL.
    always_comb begin
        buf_wr_en  = 1'b0;
        buf_wr_idx = r_q - rk_idx_t'(1);
        if (state_q == StLookup) begin
            buf_wr_en = 1'b1;
        end else if (state_q == StFinal) begin
            buf_wr_en  = 1'b1;
            buf_wr_idx = LastRound;
        end
    end

    // Reads are only honoured once the whole schedule is in the buffer.
    assign buf_rd_en = rk_rd_en && keys_ready_q;

    aes_rk_buffer #(
        .Entries (NR + 1),
        .Width   (KEY_W)
    ) u_rk_buffer (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (buf_wr_en),
        .wr_idx   (buf_wr_idx),
        .wr_data  (kx_key),
        .rd_en    (buf_rd_en),
        .rd_idx   (rk_rd_idx),
        .rd_data  (rk_rd_data),
        .rd_valid (rk_rd_valid),
        .rd_err   (rk_rd_err)
    );

    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign keys_ready = keys_ready_q;
    assign kx_load    = kx_load_q;
    assign kx_advance = kx_advance_q;
    assign kx_rcon    = kx_rcon_q;
    assign kx_key_in  = kx_key_in_q;

    // Round constant appears on the datapath only while it is advancing a round.
    a_rcon_only_update: assert property (@(posedge clk) disable iff (rst)
        (kx_rcon_q != '0) |-> (state_q == StUpdate));

    // The tenth update must use the last AES-128 round constant.
    a_rcon_final: assert property (@(posedge clk) disable iff (rst)
        (state_q == StUpdate && r_q == LastRound) |-> (rc_q == RCON_FINAL));

    // A complete schedule and an expansion in flight are mutually exclusive.
    a_ready_not_busy: assert property (@(posedge clk) disable iff (rst)
        !(keys_ready_q && busy_q));

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: behavioural expansion datapath on kx_*,
// FIPS-197 style reference key schedule, and a read-port scoreboard.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         kx_load;
    logic         kx_advance;
    logic [31:0]  kx_rcon;
    logic [127:0] kx_key;
    logic [127:0] kx_key_in;
    logic         keys_ready;
    logic         busy;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid;
    logic         rk_rd_err;

    localparam logic [127:0] FipsKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int unsigned  tests = 0;
    int unsigned  fails = 0;
    int unsigned  cycle = 0;

    logic [7:0]   sbox [256];
    logic [127:0] cur_rk [11];
    logic [127:0] next_rk [11];
    logic         tb_keys_valid = 1'b0;

    logic [127:0] exp_data_q [$];
    logic         exp_err_q [$];
    int unsigned  exp_cyc_q [$];

    logic         rcon_mon = 1'b0;
    logic [31:0]  rc_val_q [$];
    int unsigned  rc_cyc_q [$];
    int unsigned  load_cnt = 0;
    int unsigned  hs_cyc = 0;

    logic [127:0] dp_q = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    aes_key_sched_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .kx_load     (kx_load),
        .kx_advance  (kx_advance),
        .kx_rcon     (kx_rcon),
        .kx_key      (kx_key),
        .kx_key_in   (kx_key_in),
        .keys_ready  (keys_ready),
        .busy        (busy),
        .rk_rd_en    (rk_rd_en),
        .rk_rd_idx   (rk_rd_idx),
        .rk_rd_data  (rk_rd_data),
        .rk_rd_valid (rk_rd_valid),
        .rk_rd_err   (rk_rd_err)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Stand-in expansion datapath: one AES-128 round of the key state per advance.
    function automatic logic [127:0] dp_round(input logic [127:0] s, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = s[127:96] ^ subword({s[23:0], s[31:24]}) ^ {rc, 24'h0};
        n1 = s[95:64] ^ n0;
        n2 = s[63:32] ^ n1;
        n3 = s[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always @(posedge clk) begin
        if (kx_load) dp_q <= kx_key_in;
        else if (kx_advance) dp_q <= dp_round(dp_q, kx_rcon[31:24]);
    end
    assign kx_key = dp_q;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference schedule: 44-word expansion with round constants from GF(2^8) doubling.
    task automatic compute_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        int          rc;
        rc = 1;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc[7:0], 24'h0};
                rc = rc * 2;
                if (rc >= 256) rc = rc ^ 'h11b;
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) next_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_key_ready"}, key_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_keys_ready"}, keys_ready, 0);
        check({tag, "_kx_load"}, kx_load, 0);
        check({tag, "_kx_advance"}, kx_advance, 0);
        check({tag, "_kx_rcon"}, kx_rcon, 0);
        check({tag, "_kx_key_in"}, kx_key_in, 0);
        check({tag, "_rd_valid"}, rk_rd_valid, 0);
        check({tag, "_rd_err"}, rk_rd_err, 0);
        check({tag, "_rd_data"}, rk_rd_data, 0);
    endtask

    // Issue one read this cycle; expectation queued only if the bench knows it is accepted.
    task automatic rd_raw(input logic [3:0] idx, input logic [127:0] d, input logic e);
        rk_rd_en  = 1'b1;
        rk_rd_idx = idx;
        if (tb_keys_valid) begin
            exp_data_q.push_back(d);
            exp_err_q.push_back(e);
            exp_cyc_q.push_back(cycle + 1);
        end
        @(posedge clk);
        #1;
        rk_rd_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx);
        if (idx <= 4'd10) rd_raw(idx, cur_rk[idx], 1'b0);
        else rd_raw(idx, 128'h0, 1'b1);
    endtask

    task automatic rand_reads(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                rd(4'($urandom_range(0, 15)));
            end
        end
    endtask

    // Handshake a key; optionally read the old buffer in the same cycle.
    task automatic start_key(input logic [127:0] k, input logic do_rd, input logic [3:0] idx);
        check("key_ready_before_hs", key_ready, 1);
        key_in    = k;
        key_valid = 1'b1;
        hs_cyc    = cycle;
        if (do_rd) begin
            rk_rd_en  = 1'b1;
            rk_rd_idx = idx;
            exp_data_q.push_back(cur_rk[idx]);
            exp_err_q.push_back(1'b0);
            exp_cyc_q.push_back(cycle + 1);
        end
        compute_model(k);
        @(posedge clk);
        #1;
        key_valid     = 1'b0;
        rk_rd_en      = 1'b0;
        tb_keys_valid = 1'b0;
    endtask

    // Count cycles to keys_ready; optionally offer a junk key or poll reads while busy.
    task automatic wait_ready(input int jf, input int jt, input logic [127:0] exp_key,
                              input logic poll, input logic [127:0] hold);
        int n;
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("hs_keys_ready_drop", keys_ready, 0);
                check("hs_busy", busy, 1);
                check("hs_key_ready", key_ready, 0);
                check("hs_kx_load", kx_load, 1);
                check("hs_kx_advance", kx_advance, 1);
                check("hs_kx_key_in", kx_key_in, exp_key);
            end
            if (n >= jf && n <= jt) begin
                check("key_ready_busy", key_ready, 0);
                check("busy_flag", busy, 1);
                key_in    = ~exp_key;
                key_valid = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
            if (poll && n >= 2 && n <= 22) begin
                check("rd_ignored_valid", rk_rd_valid, 0);
                check("rd_hold_data", rk_rd_data, hold);
                rk_rd_en  = (n <= 20);
                rk_rd_idx = 4'($urandom_range(0, 15));
            end
            if (keys_ready) got = 1'b1;
        end
        key_valid = 1'b0;
        rk_rd_en  = 1'b0;
        check("ready_latency", n, 23);
        check("no_restart_key", kx_key_in, exp_key);
        check("done_busy", busy, 0);
        check("done_key_ready", key_ready, 1);
        cur_rk        = next_rk;
        tb_keys_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Read-port monitor: every rk_rd_valid pops one queued expectation.
    initial begin
        logic [127:0] md;
        logic         me;
        int unsigned  mc;
        forever begin
            @(negedge clk);
            if (!rst && rk_rd_valid) begin
                if (exp_data_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_unexpected: rk_rd_valid=1 data %h with no read pending",
                             rk_rd_data);
                end else begin
                    md = exp_data_q.pop_front();
                    me = exp_err_q.pop_front();
                    mc = exp_cyc_q.pop_front();
                    check("rd_data", rk_rd_data, md);
                    check("rd_err", rk_rd_err, me);
                    check("rd_latency", cycle, mc);
                end
            end
            if (!rst && rk_rd_err && !rk_rd_valid) begin
                tests++;
                fails++;
                $display("FAIL rd_err_alone: rk_rd_err=1 while rk_rd_valid=0");
            end
        end
    end

    // Round-constant monitor for the first expansion.
    initial begin
        forever begin
            @(negedge clk);
            if (rcon_mon) begin
                if (kx_rcon != 32'h0) begin
                    rc_val_q.push_back(kx_rcon);
                    rc_cyc_q.push_back(cycle);
                end
                if (kx_load) load_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] k;
        int rc;
        logic [7:0] inv;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            if (i != 0) begin
                for (int j = 1; j < 256; j++) begin
                    if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
                end
            end
            sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 11; i++) cur_rk[i] = '0;

        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_rd_en  = 1'b0;
        rk_rd_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reads before any key are ignored.
        rd(4'd3);
        check("pre_rd_valid", rk_rd_valid, 0);
        rd(4'd12);
        check("pre_rd_err", rk_rd_err, 0);
        check("pre_rd_data", rk_rd_data, 0);

        // FIPS-197 key, junk key offered while busy.
        rcon_mon = 1'b1;
        start_key(FipsKey, 1'b0, 4'd0);
        wait_ready(5, 9, FipsKey, 1'b0, '0);
        rcon_mon = 1'b0;
        check("rcon_count", rc_val_q.size(), 10);
        check("load_pulses", load_cnt, 1);
        rc = 1;
        for (int i = 0; i < 10 && i < rc_val_q.size(); i++) begin
            check("rcon_val", rc_val_q[i], {rc[7:0], 24'h0});
            if (i == 0) check("rcon_first_cycle", rc_cyc_q[0] - hs_cyc, 3);
            else check("rcon_gap", rc_cyc_q[i] - rc_cyc_q[i-1], 2);
            rc = rc * 2;
            if (rc >= 256) rc = rc ^ 'h11b;
        end

        rd_raw(4'd10, FipsRk10, 1'b0);
        for (int i = 10; i >= 0; i--) rd(4'(i));
        rd(4'd12);
        rd(4'd15);
        rand_reads(30);

        // Second key in DONE with a same-cycle read from the old buffer.
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_key(k, 1'b1, 4'd7);
        wait_ready(0, 0, k, 1'b1, cur_rk[7]);
        for (int i = 0; i <= 10; i++) rd(4'(i));
        rand_reads(30);

        // Reset at cycle 9 of an expansion.
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_key(k, 1'b0, 4'd0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_vals("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(4'($urandom_range(0, 10)));
            check("post_rst_rd_valid", rk_rd_valid, 0);
            check("post_rst_keys_ready", keys_ready, 0);
            check("post_rst_rd_data", rk_rd_data, 0);
        end

        // Fresh expansion after the abort.
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_key(k, 1'b0, 4'd0);
        wait_ready(0, 0, k, 1'b0, '0);
        for (int i = 0; i <= 10; i++) rd(4'(i));
        rand_reads(20);

        repeat (3) @(posedge clk);
        #1;
        check("rd_drain", exp_data_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
